clint: RTL

//  Core-local interruptor (CLINT). Memory-mapped responder on the core's data-bus window

---
 rtl/clint.sv | 127 ++++++++++++
 1 files changed

// File: rtl/clint.sv
// Core-local interruptor: memory-mapped mtime/mtimecmp/msip responder with RTC tick
// divider, driving the machine timer and software interrupt lines into the core.
module clint #(
   parameter logic [31:0] base_addr       = 32'h2000000,
   parameter int unsigned clk_divider_rtc = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clint_valid,
   input  logic        clint_instr,
   input  logic [31:0] clint_addr,
   input  logic [31:0] clint_wdata,
   input  logic [3:0]  clint_wstrb,
   output logic [31:0] clint_rdata,
   output logic        clint_ready,
   output logic        clint_msip,
   output logic        clint_mtip,
   output logic [63:0] clint_mtime
);

   localparam int unsigned      DIV_W   = (clk_divider_rtc > 0) ? $clog2(clk_divider_rtc + 1) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(clk_divider_rtc);

   localparam logic [15:0] OFF_MSIP     = 16'h0000;
   localparam logic [15:0] OFF_CMP_LO   = 16'h4000;
   localparam logic [15:0] OFF_CMP_HI   = 16'h4004;
   localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
   localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;

   logic [DIV_W-1:0] r_div_cnt;
   logic             r_rtc;
   logic [63:0]      r_mtime;
   logic [63:0]      r_mtimecmp;
   logic             r_msip;
   logic             r_mtip;
   logic             r_ready;
   logic [31:0]      r_rdata;

   logic [31:0] w_offset;
   logic [15:0] w_off;
   logic        w_wr;
   logic        w_wrap;
   logic        w_tick;
   logic        w_wr_mtime_lo;
   logic        w_wr_mtime_hi;
   logic [31:0] w_rd_data;
   logic [63:0] w_mtime_nxt;
   logic        w_unused;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      end
      return res;
   endfunction

   assign w_offset      = clint_addr - base_addr;
   assign w_off         = w_offset[15:0];
   assign w_wr          = clint_valid & (|clint_wstrb);
   assign w_wrap        = (r_div_cnt == DIV_MAX);
   assign w_tick        = w_wrap & ~r_rtc;
   assign w_wr_mtime_lo = w_wr & (w_off == OFF_MTIME_LO);
   assign w_wr_mtime_hi = w_wr & (w_off == OFF_MTIME_HI);
   assign w_unused      = &{1'b0, clint_instr, w_offset[31:16]};

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      w_rd_data = '0;
      case (w_off)
         OFF_MSIP:     w_rd_data = {31'd0, r_msip};
         OFF_CMP_LO:   w_rd_data = r_mtimecmp[31:0];
         OFF_CMP_HI:   w_rd_data = r_mtimecmp[63:32];
         OFF_MTIME_LO: w_rd_data = r_mtime[31:0];
         OFF_MTIME_HI: w_rd_data = r_mtime[63:32];
         default:      w_rd_data = '0;
      endcase
   end

   // A bus write to either mtime word suppresses that cycle's tick on all 64 bits.
   always_comb begin
      w_mtime_nxt = r_mtime;
      if (w_wr_mtime_lo || w_wr_mtime_hi) begin
         if (w_wr_mtime_lo) w_mtime_nxt[31:0]  = merge_bytes(r_mtime[31:0],  clint_wdata, clint_wstrb);
         if (w_wr_mtime_hi) w_mtime_nxt[63:32] = merge_bytes(r_mtime[63:32], clint_wdata, clint_wstrb);
      end else if (w_tick) begin
         w_mtime_nxt = r_mtime + 64'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_div_cnt  <= '0;
         r_rtc      <= 1'b0;
         r_mtime    <= '0;
         r_mtimecmp <= '1;
         r_msip     <= 1'b0;
         r_mtip     <= 1'b0;
         r_ready    <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_div_cnt <= w_wrap ? '0 : r_div_cnt + DIV_W'(1);
         if (w_wrap) r_rtc <= ~r_rtc;
         r_mtime <= w_mtime_nxt;
         if (w_wr && (w_off == OFF_CMP_LO))
            r_mtimecmp[31:0]  <= merge_bytes(r_mtimecmp[31:0], clint_wdata, clint_wstrb);
         if (w_wr && (w_off == OFF_CMP_HI))
            r_mtimecmp[63:32] <= merge_bytes(r_mtimecmp[63:32], clint_wdata, clint_wstrb);
         if (w_wr && (w_off == OFF_MSIP) && clint_wstrb[0])
            r_msip <= clint_wdata[0];
         r_mtip  <= (r_mtime >= r_mtimecmp);
         r_ready <= clint_valid;
         r_rdata <= clint_valid ? w_rd_data : '0;
      end
   end

   assign clint_rdata = r_rdata;
   assign clint_ready = r_ready;
   assign clint_msip  = r_msip;
   assign clint_mtip  = r_mtip;
   assign clint_mtime = r_mtime;

endmodule
